// File: rtl/instr_fetch_stage.sv
// PC generator and IF/ID pipeline register: fetches from a combinational
// instruction memory, handles stall, redirect (one bubble) and fetch faults.
//
// state | meaning
// BOOT  | one settle cycle after reset, no capture
// RUN   | normal fetch: fault check > redirect > stall > advance
// FAULT | absorbing until reset, outputs frozen
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 100,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        fetch_fault,
    output logic [31:0] fault_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] LAST_PC = 32'(IMEM_BYTES - 4);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        valid_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_pc4_q;
    logic [31:0] instr_q;
    logic        fault_q;
    logic [31:0] fault_pc_q;
    logic [31:0] count_q;

    logic [31:0] pc_plus4_d;
    logic        bad_fetch_d;

    assign pc_plus4_d  = pc_q + 32'd4;
    assign bad_fetch_d = (pc_q[1:0] != 2'b00) || (pc_q > LAST_PC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            valid_q    <= 1'b0;
            if_pc_q    <= 32'd0;
            if_pc4_q   <= 32'd0;
            instr_q    <= NOP_INSTR;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'd0;
            count_q    <= 32'd0;
        end else begin
            case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (bad_fetch_d) begin
                        // pc is held so fault_pc and imem_addr both point at the culprit
                        state_q    <= FAULT;
                        fault_q    <= 1'b1;
                        fault_pc_q <= pc_q;
                        valid_q    <= 1'b0;
                        instr_q    <= NOP_INSTR;
                    end else if (redirect_valid) begin
                        pc_q    <= redirect_pc;
                        valid_q <= 1'b0;
                        instr_q <= NOP_INSTR;
                    end else if (!stall) begin
                        valid_q  <= 1'b1;
                        if_pc_q  <= pc_q;
                        if_pc4_q <= pc_plus4_d;
                        instr_q  <= imem_data;
                        pc_q     <= pc_plus4_d;
                        count_q  <= count_q + 32'd1;
                    end
                end
                FAULT: state_q <= FAULT;
                default: state_q <= FAULT;
            endcase
        end
    end

    assign imem_addr   = pc_q;
    assign if_id_valid = valid_q;
    assign if_id_pc    = if_pc_q;
    assign if_id_pc4   = if_pc4_q;
    assign if_id_instr = instr_q;
    assign fetch_fault = fault_q;
    assign fault_pc    = fault_pc_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: directed stimulus pushes expected deliveries to a
// queue; a negedge monitor pops and compares each new IF/ID capture.
module tb_instr_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        fetch_fault;
    logic [31:0] fault_pc;
    logic [31:0] fetch_count;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] count;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem [0:31];
    logic        stall_e = 1'b0;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[6:2]];

    instr_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_BYTES(100),
        .NOP_INSTR (NOP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .if_id_valid   (if_id_valid),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4),
        .if_id_instr   (if_id_instr),
        .fetch_fault   (fetch_fault),
        .fault_pc      (fault_pc),
        .fetch_count   (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] cnt);
        exp_t e;
        e.pc    = pc;
        e.instr = instr;
        e.count = cnt;
        sb.push_back(e);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
        chk({tag, "_pc"}, if_id_pc, 32'd0);
        chk({tag, "_pc4"}, if_id_pc4, 32'd0);
        chk({tag, "_instr"}, if_id_instr, NOP);
        chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
        chk({tag, "_fault_pc"}, fault_pc, 32'd0);
        chk({tag, "_count"}, fetch_count, 32'd0);
        chk({tag, "_imem_addr"}, imem_addr, 32'd0);
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
        chk({tag, "_instr"}, if_id_instr, NOP);
    endtask

    // stall as seen by the DUT at the edge just taken
    always @(posedge clk) stall_e <= stall;

    always @(negedge clk) begin
        if (!rst && if_id_valid && !stall_e) begin
            if (sb.size() == 0) begin
                chk("unexpected_delivery_pc", if_id_pc, 32'hffff_ffff);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("deliver_pc", if_id_pc, e.pc);
                chk("deliver_pc4", if_id_pc4, e.pc + 32'd4);
                chk("deliver_instr", if_id_instr, e.instr);
                chk("deliver_count", fetch_count, e.count);
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
        mem[0] = 32'h01430f13;
        mem[1] = 32'h00030e13;
        mem[2] = 32'h000f2e83;
        mem[3] = 32'h1111_1111;
        mem[4] = 32'hfffe8e93;
        mem[6] = 32'hffce2f23;

        // reset and boot
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;
        tick();
        chk("boot_valid", {31'd0, if_id_valid}, 32'd0);
        chk("boot_imem_addr", imem_addr, 32'd0);
        push(32'd0, 32'h01430f13, 32'd1);
        push(32'd4, 32'h00030e13, 32'd2);
        push(32'd8, 32'h000f2e83, 32'd3);
        tick();
        tick();

        // stall two cycles holding pc 4
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_imem_addr", imem_addr, 32'd8);
            chk("stall_if_pc", if_id_pc, 32'd4);
            chk("stall_count", fetch_count, 32'd2);
        end
        stall = 1'b0;
        tick();
        chk("after_stall_count", fetch_count, 32'd3);
        chk("after_stall_imem_addr", imem_addr, 32'd12);

        // redirect to 24 while fetching 12
        redirect_valid = 1'b1;
        redirect_pc    = 32'd24;
        tick();
        redirect_valid = 1'b0;
        chk_bubble("redir_bubble");
        chk("redir_imem_addr", imem_addr, 32'd24);
        chk("redir_count", fetch_count, 32'd3);
        push(32'd24, 32'hffce2f23, 32'd4);
        tick();

        // redirect and stall together: redirect wins
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd16;
        tick();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        chk_bubble("redir_stall_bubble");
        chk("redir_stall_imem_addr", imem_addr, 32'd16);
        push(32'd16, 32'hfffe8e93, 32'd5);
        tick();

        // misaligned redirect faults one edge after load
        redirect_valid = 1'b1;
        redirect_pc    = 32'd6;
        tick();
        redirect_valid = 1'b0;
        chk("misalign_load_fault", {31'd0, fetch_fault}, 32'd0);
        chk("misalign_load_addr", imem_addr, 32'd6);
        tick();
        chk("misalign_fault", {31'd0, fetch_fault}, 32'd1);
        chk("misalign_fault_pc", fault_pc, 32'd6);
        chk_bubble("misalign_bubble");
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        tick();
        redirect_valid = 1'b0;
        chk("misalign_sticky", {31'd0, fetch_fault}, 32'd1);
        chk("misalign_held_addr", imem_addr, 32'd6);
        chk("misalign_count", fetch_count, 32'd5);

        // reset clears the fault; run off the end of memory
        rst = 1'b1;
        tick();
        chk_reset("reset2");
        rst = 1'b0;
        tick();
        push(32'd0, 32'h01430f13, 32'd1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'd88;
        tick();
        redirect_valid = 1'b0;
        chk_bubble("range_redir_bubble");
        push(32'd88, 32'h1000_0016, 32'd2);
        push(32'd92, 32'h1000_0017, 32'd3);
        push(32'd96, 32'h1000_0018, 32'd4);
        tick();
        tick();
        tick();
        chk("range_pre_fault", {31'd0, fetch_fault}, 32'd0);
        chk("range_addr", imem_addr, 32'd100);
        tick();
        chk("range_fault", {31'd0, fetch_fault}, 32'd1);
        chk("range_fault_pc", fault_pc, 32'd100);
        chk_bubble("range_bubble");
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        tick();
        tick();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        chk("range_sticky", {31'd0, fetch_fault}, 32'd1);
        chk("range_held_addr", imem_addr, 32'd100);
        chk("range_count", fetch_count, 32'd4);

        // reset mid-operation while stalled with valid IF/ID
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        push(32'd0, 32'h01430f13, 32'd1);
        push(32'd4, 32'h00030e13, 32'd2);
        tick();
        tick();
        stall = 1'b1;
        tick();
        chk("mid_stall_valid", {31'd0, if_id_valid}, 32'd1);
        rst = 1'b1;
        tick();
        chk_reset("mid_reset");
        rst   = 1'b0;
        stall = 1'b0;
        tick();
        chk("mid_boot_valid", {31'd0, if_id_valid}, 32'd0);
        chk("mid_boot_addr", imem_addr, 32'd0);
        push(32'd0, 32'h01430f13, 32'd1);
        tick();
        @(negedge clk);
        #1;
        chk("scoreboard_left", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
PC generator and IF/ID pipeline register for the RV32 core. Drives a byte address to the combinational instruction memory and captures the returned 32-bit word, with its PC, into the IF/ID register. Handles stall, branch/jump redirect with a one-bubble flush, and fetch-fault detection. Sits directly upstream of the decode stage.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
IMEM_BYTES, 100, instruction memory size in bytes; a fetch is legal only if pc <= IMEM_BYTES-4
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; synchronous, active-high
stall  input  1  hold PC and IF/ID contents (decode not ready)
redirect_valid  input  1  taken branch/jump from execute
redirect_pc  input  32  redirect target byte address
imem_addr  output  32  current PC to instruction memory (combinational from pc register)
imem_data  input  32  instruction word returned combinationally for imem_addr
if_id_valid  output  1  IF/ID holds a real instruction
if_id_pc  output  32  PC of captured instruction
if_id_pc4  output  32  if_id_pc + 4 (mod 2^32)
if_id_instr  output  32  captured instruction, or NOP_INSTR when not valid
fetch_fault  output  1  sticky fault flag
fault_pc  output  32  PC that caused the fault
fetch_count  output  32  count of instructions delivered to IF/ID

Behaviour:
- States: BOOT, RUN, FAULT. imem_addr = pc register at all times.
- Reset (rst high at edge, overrides everything): pc=RESET_PC, state=BOOT, if_id_valid=0, if_id_pc=0, if_id_pc4=0, if_id_instr=NOP_INSTR, fetch_fault=0, fault_pc=0, fetch_count=0.
- BOOT: exactly one cycle after rst deasserts; no capture, pc unchanged, IF/ID stays bubble. Lets instruction memory settle its reset-time load. -> RUN unconditionally (stall/redirect ignored in BOOT).
- RUN, priority per edge: fault check > redirect > stall > advance.
  - Fault check: pc[1:0]!=0 or pc > IMEM_BYTES-4 -> state=FAULT, fetch_fault=1, fault_pc=pc, IF/ID <- bubble, pc held. Takes precedence over redirect and stall.
  - Redirect: pc <= redirect_pc, IF/ID <- bubble (valid=0, instr=NOP_INSTR), count unchanged. Wins over stall. Misaligned target is loaded and faults on the following edge.
  - Stall (no redirect): pc and all IF/ID fields held, count unchanged.
  - Advance: IF/ID <- {valid=1, pc, pc+4, imem_data}; pc <= pc+4; fetch_count += 1 (wraps 2^32-1 -> 0).
- FAULT: absorbing until rst; redirect and stall ignored; outputs frozen with if_id_valid=0.
- Latency: instruction at PC appears on IF/ID outputs one cycle after imem_addr=PC with no stall; redirect costs exactly one bubble cycle.
- pc+4 arithmetic is 32-bit, wraps silently (range fault catches out-of-memory first).
- All outputs registered except imem_addr (direct from pc register).

Test Plan:
- Reset/boot: imem loaded with 0x01430f13@0, 0x00030e13@4, 0x000f2e83@8; release rst -> one BOOT cycle with if_id_valid=0, then IF/ID shows (pc 0, 0x01430f13), (pc 4, 0x00030e13), (pc 8, 0x000f2e83) on consecutive cycles; fetch_count=3.
- Stall: assert stall 2 cycles while IF/ID holds pc 4 -> IF/ID, imem_addr=8, and fetch_count frozen; release -> pc 8 delivered next cycle.
- Redirect: redirect_valid with redirect_pc=24 while imem_addr=12 -> next cycle bubble (valid=0, instr=0x00000013), following cycle IF/ID pc 24, instr 0xffce2f23; pc 12 never delivered.
- Redirect+stall same cycle: stall=1, redirect_pc=16 -> redirect wins; bubble then pc 16, 0xfffe8e93.
- Faults: redirect_pc=6 -> fetch_fault=1, fault_pc=6 one cycle after load; separately advance to pc=100 with IMEM_BYTES=100 -> fault_pc=100; redirects afterward ignored; rst clears fault and restarts at 0.
- Reset mid-operation: assert rst during stall with valid IF/ID -> all outputs return to reset values next edge, BOOT repeats.
